// File: rtl/decode_issue.sv
// Decode/issue stage ahead of the 16x32 register file: one-entry decode buffer,
// 16-bit scoreboard, regfile read-port drive and execute payload register.
// Optional macro WB_BYPASS_EN lets a writeback in the current cycle unblock a dependent issue.
module decode_issue #(
  parameter int OPW        = 4,
  parameter int IMMW       = 16,
  parameter int WE_LAST_OP = 11,
  parameter int NOP_OP     = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            rd_allow,
  output logic [3:0]      Rs1,
  output logic [3:0]      Rs2,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [OPW-1:0]  ex_op,
  output logic [3:0]      ex_rd,
  output logic            ex_we,
  output logic [IMMW-1:0] ex_imm,
  input  logic            wb_valid,
  input  logic [3:0]      wb_rd
);

  function automatic logic hazard_f(
    input logic [15:0] pend,
    input logic [3:0]  rs1,
    input logic [3:0]  rs2,
    input logic [3:0]  rd,
    input logic        we,
    input logic        nop
  );
    return !nop && (pend[rs1] || pend[rs2] || (we && pend[rd]));
  endfunction

  logic            r_vld_p0;
  logic [31:0]     r_instr_p0;
  logic            r_vld_p1;
  logic [OPW-1:0]  r_op_p1;
  logic [3:0]      r_rd_p1;
  logic            r_we_p1;
  logic [IMMW-1:0] r_imm_p1;
  logic [3:0]      r_rs1_p1;
  logic [3:0]      r_rs2_p1;
  logic [15:0]     r_pending;

  logic [OPW-1:0]  w_op;
  logic [3:0]      w_rd;
  logic [3:0]      w_rs1;
  logic [3:0]      w_rs2;
  logic [IMMW-1:0] w_imm;
  logic            w_is_nop;
  logic            w_we;
  logic [3:0]      w_src1;
  logic [3:0]      w_src2;
  logic [15:0]     w_wb_mask;
  logic [15:0]     w_eff_pending;
  logic            w_hazard;
  logic            w_hold;
  logic            w_issue;
  logic            w_load;
  logic [15:0]     w_pending_nxt;

  // p0: decode-buffer field extraction
  assign w_op     = r_instr_p0[31 -: OPW];
  assign w_rd     = r_instr_p0[27:24];
  assign w_rs1    = r_instr_p0[23:20];
  assign w_rs2    = r_instr_p0[19:16];
  assign w_imm    = r_instr_p0[IMMW-1:0];
  assign w_is_nop = (w_op == OPW'(NOP_OP));
  assign w_we     = (w_op <= OPW'(WE_LAST_OP));
  // A NOP reads r0/r0 so the regfile access is harmless.
  assign w_src1   = w_is_nop ? 4'd0 : w_rs1;
  assign w_src2   = w_is_nop ? 4'd0 : w_rs2;

  assign w_wb_mask = wb_valid ? (16'h1 << wb_rd) : 16'h0;
`ifdef WB_BYPASS_EN
  // Regfile writes on negedge, so the posedge read already sees the retiring value.
  assign w_eff_pending = r_pending & ~w_wb_mask;
`else
  assign w_eff_pending = r_pending;
`endif

  assign w_hazard = hazard_f(w_eff_pending, w_rs1, w_rs2, w_rd, w_we, w_is_nop);
  assign w_hold   = r_vld_p1 && !ex_ready;
  assign w_issue  = r_vld_p0 && !w_hazard && !w_hold;
  assign in_ready = !rst && (!r_vld_p0 || w_issue);
  assign w_load   = in_valid && in_ready;

  // While execute holds, re-read its sources so D1/D2 stay stable.
  always_comb begin
    rd_allow = 1'b0;
    Rs1      = 4'd0;
    Rs2      = 4'd0;
    if (w_issue) begin
      rd_allow = 1'b1;
      Rs1      = w_src1;
      Rs2      = w_src2;
    end else if (w_hold) begin
      rd_allow = 1'b1;
      Rs1      = r_rs1_p1;
      Rs2      = r_rs2_p1;
    end
  end

  // Set is applied after clear so a same-edge issue to wb_rd keeps the bit.
  always_comb begin
    w_pending_nxt = r_pending & ~w_wb_mask;
    if (w_issue && w_we) begin
      w_pending_nxt[w_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
    end else if (w_load) begin
      r_vld_p0 <= 1'b1;
    end else if (w_issue) begin
      r_vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_instr_p0 <= in_instr;
    end
  end

  // p0 -> p1: issue into the execute register, aligned with the regfile read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_op_p1  <= '0;
      r_rd_p1  <= 4'd0;
      r_we_p1  <= 1'b0;
      r_imm_p1 <= '0;
      r_rs1_p1 <= 4'd0;
      r_rs2_p1 <= 4'd0;
    end else if (w_issue) begin
      r_vld_p1 <= 1'b1;
      r_op_p1  <= w_op;
      r_rd_p1  <= w_rd;
      r_we_p1  <= w_we;
      r_imm_p1 <= w_imm;
      r_rs1_p1 <= w_src1;
      r_rs2_p1 <= w_src2;
    end else if (r_vld_p1 && ex_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 16'h0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign ex_valid = r_vld_p1;
  assign ex_op    = r_op_p1;
  assign ex_rd    = r_rd_p1;
  assign ex_we    = r_we_p1;
  assign ex_imm   = r_imm_p1;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: vector table, hand-built hazard/reset
// sequences and a randomized run against a queue-based reference model.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        rd_allow;
  logic [3:0]  Rs1;
  logic [3:0]  Rs2;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_op;
  logic [3:0]  ex_rd;
  logic        ex_we;
  logic [15:0] ex_imm;
  logic        wb_valid;
  logic [3:0]  wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  decode_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rd_allow(rd_allow), .Rs1(Rs1), .Rs2(Rs2), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_we(ex_we), .ex_imm(ex_imm),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2, input int imm);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
  endfunction

  task automatic drv(input logic iv, input logic [31:0] ins, input logic exr, input logic wbv, input logic [3:0] wbr);
    in_valid = iv;
    in_instr = ins;
    ex_ready = exr;
    wb_valid = wbv;
    wb_rd    = wbr;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic        exr;
    logic        e_rdy;
    logic        e_ra;
    logic [3:0]  e_rs1;
    logic [3:0]  e_rs2;
    logic        e_xv;
    logic [3:0]  e_op;
    logic [3:0]  e_rd;
    logic        e_we;
    logic [15:0] e_imm;
  } vec_t;

  function automatic vec_t mkv(input logic iv, input logic [31:0] ins, input logic exr, input logic rdy,
                               input logic ra, input int s1, input int s2, input logic xv,
                               input int op, input int rd, input logic we, input int imm);
    vec_t v;
    v.iv = iv; v.instr = ins; v.exr = exr; v.e_rdy = rdy; v.e_ra = ra;
    v.e_rs1 = s1[3:0]; v.e_rs2 = s2[3:0]; v.e_xv = xv;
    v.e_op = op[3:0]; v.e_rd = rd[3:0]; v.e_we = we; v.e_imm = imm[15:0];
    return v;
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
  } ins_t;

  vec_t vt[12];

  // Reference-model state
  ins_t dq[$];
  ins_t mx;
  bit   mxv;
  bit   mpend[16];

  initial begin
    logic [31:0] i1, i2, i3, i4;
    rst = 1'b1;
    drv(1'b0, 32'h0, 1'b1, 1'b0, 4'd0);
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_rd_allow", rd_allow, 0);
    chk("rst_rs", {Rs1, Rs2}, 0);
    chk("rst_ex_fields", {ex_op, ex_rd, ex_we, ex_imm}, 0);
    chk("rst_pending", dut.r_pending, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back issue, then execute backpressure with sources r7/r9
    i1 = mk(0, 1, 2, 3, 16'h1111);
    i2 = mk(0, 4, 5, 6, 16'h2222);
    i3 = mk(0, 10, 7, 9, 16'h3333);
    i4 = mk(13, 11, 12, 13, 16'h4444);
    vt[0]  = mkv(1, i1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mkv(1, i2, 1, 1, 1, 2, 3, 0, 0, 0, 0, 0);
    vt[2]  = mkv(0, 0, 1, 1, 1, 5, 6, 1, 0, 1, 1, 16'h1111);
    vt[3]  = mkv(0, 0, 1, 1, 0, 0, 0, 1, 0, 4, 1, 16'h2222);
    vt[4]  = mkv(1, i3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[5]  = mkv(1, i4, 1, 1, 1, 7, 9, 0, 0, 0, 0, 0);
    vt[6]  = mkv(0, 0, 0, 0, 1, 7, 9, 1, 0, 10, 1, 16'h3333);
    vt[7]  = mkv(0, 0, 0, 0, 1, 7, 9, 1, 0, 10, 1, 16'h3333);
    vt[8]  = mkv(0, 0, 0, 0, 1, 7, 9, 1, 0, 10, 1, 16'h3333);
    vt[9]  = mkv(0, 0, 1, 1, 1, 12, 13, 1, 0, 10, 1, 16'h3333);
    vt[10] = mkv(0, 0, 1, 1, 0, 0, 0, 1, 13, 11, 0, 16'h4444);
    vt[11] = mkv(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      drv(vt[i].iv, vt[i].instr, vt[i].exr, 1'b0, 4'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].e_rdy);
      chk($sformatf("vec%0d_rd_port", i), {rd_allow, Rs1, Rs2}, {vt[i].e_ra, vt[i].e_rs1, vt[i].e_rs2});
      chk($sformatf("vec%0d_ex_valid", i), ex_valid, vt[i].e_xv);
      if (vt[i].e_xv)
        chk($sformatf("vec%0d_ex_fields", i), {ex_op, ex_rd, ex_we, ex_imm},
            {vt[i].e_op, vt[i].e_rd, vt[i].e_we, vt[i].e_imm});
      if (i == 4) chk("vec_pending_b2b", dut.r_pending, 16'h0012);
      nxt();
    end
    chk("vec_pending_end", dut.r_pending, 16'h0412);

    // Reset while FULL with hold and hazard
    do_reset();
    drv(1, mk(0, 1, 2, 3, 0), 1, 0, 0);
    nxt();
    drv(1, mk(0, 5, 1, 4, 0), 1, 0, 0);
    nxt();
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_state", {ex_valid, rd_allow}, 2'b11);
    rst = 1'b1;
    #1;
    chk("midrst_ex_valid", ex_valid, 0);
    chk("midrst_rd_allow", rd_allow, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_pending", dut.r_pending, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drv(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_idle", {ex_valid, rd_allow}, 0);
    nxt();

    // RAW stall on r1, released by writeback three cycles after the producer issues
    do_reset();
    drv(1, mk(0, 1, 2, 3, 16'h00aa), 1, 0, 0);
    nxt();
    drv(1, mk(0, 5, 1, 4, 16'h00bb), 1, 0, 0);
    @(negedge clk);
    chk("raw_load_rdy", in_ready, 1);
    nxt();
    drv(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("raw_stall1", {in_ready, rd_allow}, 0);
    nxt();
    @(negedge clk);
    chk("raw_stall2", {in_ready, rd_allow}, 0);
    nxt();
    drv(0, 0, 1, 1, 4'd1);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("raw_wb_issue", {in_ready, rd_allow, Rs1, Rs2}, {1'b1, 1'b1, 4'd1, 4'd4});
    nxt();
    drv(0, 0, 1, 0, 0);
`else
    chk("raw_wb_stall", {in_ready, rd_allow}, 0);
    nxt();
    drv(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("raw_late_issue", {in_ready, rd_allow, Rs1, Rs2}, {1'b1, 1'b1, 4'd1, 4'd4});
    nxt();
`endif
    chk("raw_pending", dut.r_pending, 16'h0020);
    chk("raw_ex", {ex_valid, ex_rd, ex_imm}, {1'b1, 4'd5, 16'h00bb});

    // Writeback of r3 coincident with a WAW-dependent write to r3
    do_reset();
    drv(1, mk(0, 3, 0, 0, 0), 1, 0, 0);
    nxt();
    drv(1, mk(2, 3, 0, 0, 0), 1, 0, 0);
    nxt();
    drv(0, 0, 1, 1, 4'd3);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("same_edge_issue", rd_allow, 1);
    nxt();
    chk("same_edge_pend3", dut.r_pending[3], 1);
    chk("same_edge_exop", ex_op, 2);
`else
    chk("same_edge_stall", rd_allow, 0);
    nxt();
    chk("same_edge_clr3", dut.r_pending[3], 0);
    drv(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("same_edge_late", rd_allow, 1);
    nxt();
    chk("same_edge_pend3", dut.r_pending[3], 1);
`endif

    // Non-writing opcode whose Rd field names a pending register
    do_reset();
    drv(1, mk(0, 8, 0, 0, 0), 1, 0, 0);
    nxt();
    drv(1, mk(12, 8, 1, 2, 16'h0055), 1, 0, 0);
    nxt();
    drv(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("nowe_issue", {in_ready, rd_allow, Rs1, Rs2}, {1'b1, 1'b1, 4'd1, 4'd2});
    nxt();
    chk("nowe_ex", {ex_valid, ex_op, ex_rd, ex_we}, {1'b1, 4'd12, 4'd8, 1'b0});
    chk("nowe_pending", dut.r_pending, 16'h0100);

    // Randomized run against the reference model
    do_reset();
    dq.delete();
    mxv = 0;
    mx = '{default: 0};
    for (int r = 0; r < 16; r++) mpend[r] = 0;
    for (int c = 0; c < 3000; c++) begin
      ins_t ni, h;
      bit iv, exr, wbv, nop, we, haz, hold, iss, erdy, era;
      logic [3:0] wbr, es1, es2;
      bit eff[16];
      logic [51:0] act, exp;
      iv  = ($urandom_range(0, 3) != 0);
      ni.op  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      ni.rd  = 4'($urandom_range(0, 3));
      ni.rs1 = 4'($urandom_range(0, 3));
      ni.rs2 = 4'($urandom_range(0, 3));
      ni.imm = 16'($urandom);
      exr = ($urandom_range(0, 3) != 0);
      wbv = ($urandom_range(0, 2) == 0);
      wbr = 4'($urandom_range(0, 3));
      drv(iv, {ni.op, ni.rd, ni.rs1, ni.rs2, ni.imm}, exr, wbv, wbr);

      for (int r = 0; r < 16; r++) eff[r] = mpend[r];
`ifdef WB_BYPASS_EN
      if (wbv) eff[wbr] = 0;
`endif
      hold = mxv && !exr;
      iss = 0;
      nop = 0;
      we = 0;
      if (dq.size() > 0) begin
        h = dq[0];
        nop = (h.op == 4'd15);
        we = (h.op <= 4'd11);
        haz = !nop && (eff[h.rs1] || eff[h.rs2] || (we && eff[h.rd]));
        iss = !haz && !hold;
        if (nop) begin
          h.rs1 = 0;
          h.rs2 = 0;
        end
      end
      erdy = (dq.size() == 0) || iss;
      era = iss || hold;
      es1 = iss ? h.rs1 : (hold ? mx.rs1 : 4'd0);
      es2 = iss ? h.rs2 : (hold ? mx.rs2 : 4'd0);

      @(negedge clk);
      exp = {erdy, era, es1, es2, mxv, mxv ? {mx.op, mx.rd, (mx.op <= 4'd11), mx.imm} : 25'h0, 16'h0};
      for (int r = 0; r < 16; r++) exp[r] = mpend[r];
      act = {in_ready, rd_allow, Rs1, Rs2, ex_valid, ex_valid ? {ex_op, ex_rd, ex_we, ex_imm} : 25'h0, dut.r_pending};
      chk($sformatf("rand_c%0d", c), act, exp);

      if (wbv) mpend[wbr] = 0;
      if (iss && we) mpend[h.rd] = 1;
      if (iss) begin
        mx = h;
        mxv = 1;
        void'(dq.pop_front());
      end else if (mxv && exr) begin
        mxv = 0;
      end
      if (iv && erdy) dq.push_back(ni);
      nxt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
